// File: rtl/bomb_timer_pkg.sv
// rtl/bomb_timer_pkg.sv - state codes, BCD constants and load clamp helper for the bomb countdown timer
package bomb_timer_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_RUN     = 3'd1;
   localparam logic [2:0] ST_PAUSE   = 3'd2;
   localparam logic [2:0] ST_EXPIRED = 3'd3;
   localparam logic [2:0] ST_DEFUSED = 3'd4;

   localparam int         DIGIT_W      = 4;
   localparam logic [3:0] MAX_DIGIT    = 4'd9;
   localparam logic [3:0] MAX_SEC_TENS = 4'd5;

   // Forces an arbitrary 16-bit load word into a legal MM:SS BCD value.
   function automatic logic [15:0] clamp_mmss(input logic [15:0] v);
      logic [15:0] r;
      for (int i = 0; i < 4; i++) begin
         r[i*DIGIT_W +: DIGIT_W] = (v[i*DIGIT_W +: DIGIT_W] > MAX_DIGIT) ?
                                   MAX_DIGIT : v[i*DIGIT_W +: DIGIT_W];
      end
      if (r[7:4] > MAX_SEC_TENS)
         r[7:4] = MAX_SEC_TENS;
      return r;
   endfunction

endpackage

// File: rtl/bcd_mmss_dec.sv
// rtl/bcd_mmss_dec.sv - combinational one-second decrement of an MM:SS BCD value with zero/warning flags
module bcd_mmss_dec #(
   parameter int WARN_SEC = 10
) (
   input  logic [15:0] time_in,
   output logic [15:0] time_next,
   output logic        is_zero,
   output logic        le_warn
);
   import bomb_timer_pkg::*;

   logic [3:0] so, st, mo, mt;
   int         total;

   assign so      = time_in[3:0];
   assign st      = time_in[7:4];
   assign mo      = time_in[11:8];
   assign mt      = time_in[15:12];
   assign is_zero = (time_in == 16'h0000);

   always_comb begin
      total   = int'(mt) * 600 + int'(mo) * 60 + int'(st) * 10 + int'(so);
      le_warn = (total <= WARN_SEC);
   end

   // 00:00 is held rather than wrapped.
   always_comb begin
      time_next = time_in;
      if (!is_zero) begin
         if (so != 4'd0) begin
            time_next[3:0] = so - 4'd1;
         end else begin
            time_next[3:0] = MAX_DIGIT;
            if (st != 4'd0) begin
               time_next[7:4] = st - 4'd1;
            end else begin
               time_next[7:4] = MAX_SEC_TENS;
               if (mo != 4'd0) begin
                  time_next[11:8] = mo - 4'd1;
               end else begin
                  time_next[11:8]  = MAX_DIGIT;
                  time_next[15:12] = mt - 4'd1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/bomb_countdown_timer.sv
// rtl/bomb_countdown_timer.sv - MM:SS bomb countdown with pause, defuse, penalties, beep and blink
// Optional penalty accumulation is enabled by defining TIMER_PENALTY_EN.
module bomb_countdown_timer #(
   parameter int PENALTY_SEC = 10,
   parameter int WARN_SEC    = 10,
   parameter int BLINK_TICKS = 50
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick_1sec,
   input  logic        tick_10ms,
   input  logic        load,
   input  logic [15:0] load_bcd,
   input  logic        start,
   input  logic        pause,
   input  logic        defuse,
   input  logic        penalty,
   output logic [15:0] time_bcd,
   output logic [2:0]  state_o,
   output logic        timeout_pulse,
   output logic        beep,
   output logic        blink
);
   import bomb_timer_pkg::*;

`ifdef TIMER_PENALTY_EN
   localparam int PEND_W = 8;
`else
   localparam int PEND_W = 2;
`endif
   localparam logic [9:0]        PEND_MAX   = 10'((1 << PEND_W) - 1);
   localparam int                BCNT_W     = $clog2(BLINK_TICKS + 1);
   localparam logic [BCNT_W-1:0] BLINK_LAST = BCNT_W'(BLINK_TICKS - 1);

   logic [2:0]        state;
   logic [PEND_W-1:0] pending;
   logic [BCNT_W-1:0] blink_cnt;
   logic [15:0]       dec_next;
   logic              is_zero, le_warn;
   logic              cmd_load, cmd_defuse, cmd_pause, cmd_start;
   logic              tick_acc, drain, expire, blink_active;
   logic [9:0]        pen_inc, pend_sum;

   bcd_mmss_dec #(.WARN_SEC(WARN_SEC)) u_dec (
      .time_in   (time_bcd),
      .time_next (dec_next),
      .is_zero   (is_zero),
      .le_warn   (le_warn)
   );

   // Only the highest-priority asserted command is considered each cycle.
   assign cmd_load   = load;
   assign cmd_defuse = defuse & ~load;
   assign cmd_pause  = pause & ~load & ~defuse;
   assign cmd_start  = start & ~load & ~defuse & ~pause;

`ifdef TIMER_PENALTY_EN
   logic cmd_penalty;
   assign cmd_penalty = penalty & ~(load | defuse | pause | start);
   assign pen_inc = (cmd_penalty && (state == ST_RUN || state == ST_PAUSE)) ?
                    10'(PENALTY_SEC) : 10'd0;
`else
   logic unused_penalty;
   assign unused_penalty = penalty | (PENALTY_SEC == 0);
   assign pen_inc        = 10'd0;
`endif

   assign tick_acc     = tick_1sec && (state == ST_RUN);
   assign drain        = (state == ST_RUN) && (pending != '0) && !is_zero;
   assign expire       = drain && (dec_next == 16'h0000);
   assign pend_sum     = 10'(pending) + 10'(tick_acc) + pen_inc - 10'(drain);
   assign blink_active = (state == ST_EXPIRED) || ((state == ST_RUN) && le_warn);
   assign state_o      = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= ST_IDLE;
         time_bcd      <= 16'h0000;
         pending       <= '0;
         timeout_pulse <= 1'b0;
         beep          <= 1'b0;
         blink         <= 1'b1;
         blink_cnt     <= '0;
      end else begin
         timeout_pulse <= expire;
         beep          <= tick_acc && le_warn;
         pending       <= (pend_sum > PEND_MAX) ? PEND_MAX[PEND_W-1:0] : pend_sum[PEND_W-1:0];
         if (drain)
            time_bcd <= dec_next;

         if (expire) begin
            state   <= ST_EXPIRED;
            pending <= '0;
         end else if (cmd_load && state != ST_RUN) begin
            state    <= ST_IDLE;
            time_bcd <= clamp_mmss(load_bcd);
            pending  <= '0;
         end else if (cmd_defuse && (state == ST_RUN || state == ST_PAUSE)) begin
            state <= ST_DEFUSED;
         end else if (cmd_pause && state == ST_RUN) begin
            state <= ST_PAUSE;
         end else if (cmd_start && ((state == ST_IDLE && !is_zero) || state == ST_PAUSE)) begin
            state <= ST_RUN;
         end

         if (!blink_active) begin
            blink     <= 1'b1;
            blink_cnt <= '0;
         end else if (tick_10ms) begin
            if (blink_cnt == BLINK_LAST) begin
               blink_cnt <= '0;
               blink     <= ~blink;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
      end
   end

endmodule
